plab5_mcore_mem_req_sched: RTL and testbench

Two-requester memory request scheduler that shares one memory request port and routes the in-order responses back. Each requester presents a full memory request message plus its security domain bit; the scheduler picks a winner round-robin, issues it, remembers who issued it, and steers the matching response. It sits between the per-core request streams (whose control fields are unpacked downstream by the memory-request control-message unpacker) and the single memory/network port of the multicore.

---
 rtl/plab5_mcore_mem_req_sched.sv | 206 ++++++++++++++++++++
 tb/tb_plab5_mcore_mem_req_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plab5_mcore_mem_req_sched.sv
// plab5_mcore_mem_req_sched
// Two-requester round-robin memory request scheduler. It shares one memory
// request port between two requesters, records the issuing requester of each
// request in a small FIFO, and steers the in-order responses back to that
// requester.
//
// Optional feature: define PLAB5_MCORE_MEMREQ_SCHED_DOMAIN_ISO_EN to enable
// domain-switch draining. Before a request from a different security domain
// is issued, all outstanding requests must first complete.
//
// Message widths follow the vc memory message layout:
//   req  = {type(3), opaque(o), addr(a), len(clog2(d/8)), data(d)}
//   resp = {type(3), opaque(o), len(clog2(d/8)), data(d)}

module plab5_mcore_mem_req_sched #(
  parameter int p_opaque_nbits    = 8,
  parameter int p_addr_nbits      = 32,
  parameter int p_data_nbits      = 32,
  parameter int p_max_outstanding = 4,
  localparam int req_nbits  = 3 + p_opaque_nbits + p_addr_nbits
                              + $clog2(p_data_nbits/8) + p_data_nbits,
  localparam int resp_nbits = 3 + p_opaque_nbits
                              + $clog2(p_data_nbits/8) + p_data_nbits
)(
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_val,
  output logic                  req0_rdy,
  input  logic [req_nbits-1:0]  req0_msg,
  input  logic                  req0_domain,

  input  logic                  req1_val,
  output logic                  req1_rdy,
  input  logic [req_nbits-1:0]  req1_msg,
  input  logic                  req1_domain,

  output logic                  memreq_val,
  input  logic                  memreq_rdy,
  output logic [req_nbits-1:0]  memreq_msg,
  output logic                  memreq_domain,

  input  logic                  memresp_val,
  output logic                  memresp_rdy,
  input  logic [resp_nbits-1:0] memresp_msg,

  output logic                  resp0_val,
  input  logic                  resp0_rdy,
  output logic [resp_nbits-1:0] resp0_msg,

  output logic                  resp1_val,
  input  logic                  resp1_rdy,
  output logic [resp_nbits-1:0] resp1_msg
);

  localparam int ptr_nbits = $clog2(p_max_outstanding);
  localparam int cnt_nbits = ptr_nbits + 1;
  localparam logic [cnt_nbits-1:0] cnt_max = cnt_nbits'(p_max_outstanding);

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Architectural state
  logic                         ptr_r;      // round-robin priority
  logic [p_max_outstanding-1:0] fifo_r;     // issuing requester ids
  logic [ptr_nbits-1:0]         wr_ptr_r;
  logic [ptr_nbits-1:0]         rd_ptr_r;
  logic [cnt_nbits-1:0]         count_r;
  state_t                       state_r;
`ifdef PLAB5_MCORE_MEMREQ_SCHED_DOMAIN_ISO_EN
  logic                         cur_domain_r;
  logic                         pending_domain_r;
`endif

  // Combinational decisions
  logic win_val_s;
  logic win_id_s;
  logic win_domain_s;
  logic not_full_s;
  logic not_empty_s;
  logic domain_ok_s;
  logic issue_s;
  logic req_fire_s;
  logic head_s;
  logic resp_fire_s;

  // Round-robin winner selection: the priority pointer breaks ties
  always_comb begin
    win_val_s = 1'b0;
    win_id_s  = 1'b0;
    if (req0_val && req1_val) begin
      win_val_s = 1'b1;
      win_id_s  = ptr_r;
    end else if (req0_val) begin
      win_val_s = 1'b1;
      win_id_s  = 1'b0;
    end else if (req1_val) begin
      win_val_s = 1'b1;
      win_id_s  = 1'b1;
    end else begin
      win_val_s = 1'b0;
      win_id_s  = 1'b0;
    end
  end

  assign win_domain_s = win_id_s ? req1_domain : req0_domain;
  assign not_full_s   = (count_r < cnt_max);
  assign not_empty_s  = (count_r != {cnt_nbits{1'b0}});

`ifdef PLAB5_MCORE_MEMREQ_SCHED_DOMAIN_ISO_EN
  // An empty tracker lets a domain switch take effect in the same cycle
  assign domain_ok_s = (win_domain_s == cur_domain_r) || !not_empty_s;
`else
  assign domain_ok_s = 1'b1;
`endif

  // Full is judged on the registered count, so a same-cycle pop cannot
  // open a slot for a push.
  assign issue_s = !reset && win_val_s && not_full_s && domain_ok_s
                   && (state_r == ST_ISSUE);

  assign memreq_val    = issue_s;
  assign memreq_msg    = win_id_s ? req1_msg : req0_msg;
  assign memreq_domain = win_domain_s;
  assign req0_rdy      = issue_s && memreq_rdy && !win_id_s;
  assign req1_rdy      = issue_s && memreq_rdy &&  win_id_s;
  assign req_fire_s    = issue_s && memreq_rdy;

  // Response steering: the FIFO head names the requester owning the response.
  // An empty tracker refuses stray responses instead of guessing.
  assign head_s      = fifo_r[rd_ptr_r];
  assign resp0_val   = !reset && memresp_val && not_empty_s && !head_s;
  assign resp1_val   = !reset && memresp_val && not_empty_s &&  head_s;
  assign memresp_rdy = !reset && not_empty_s && (head_s ? resp1_rdy : resp0_rdy);
  assign resp_fire_s = memresp_val && memresp_rdy;
  assign resp0_msg   = memresp_msg;
  assign resp1_msg   = memresp_msg;

  // Tracking FIFO, occupancy count and round-robin pointer update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r    <= 1'b0;
      fifo_r   <= {p_max_outstanding{1'b0}};
      wr_ptr_r <= {ptr_nbits{1'b0}};
      rd_ptr_r <= {ptr_nbits{1'b0}};
      count_r  <= {cnt_nbits{1'b0}};
    end else begin
      if (req_fire_s) begin
        fifo_r[wr_ptr_r] <= win_id_s;
        wr_ptr_r         <= wr_ptr_r + ptr_nbits'(1);
        ptr_r            <= !win_id_s;
      end
      if (resp_fire_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_nbits'(1);
      end
      case ({req_fire_s, resp_fire_s})
        2'b10:   count_r <= count_r + cnt_nbits'(1);
        2'b01:   count_r <= count_r - cnt_nbits'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef PLAB5_MCORE_MEMREQ_SCHED_DOMAIN_ISO_EN
  // Domain-switch FSM: drain every outstanding request before changing domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= ST_ISSUE;
      cur_domain_r     <= 1'b0;
      pending_domain_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ISSUE: begin
          if (win_val_s && (win_domain_s != cur_domain_r)) begin
            if (not_empty_s) begin
              state_r          <= ST_DRAIN;
              pending_domain_r <= win_domain_s;
            end else begin
              cur_domain_r <= win_domain_s;
            end
          end
        end
        ST_DRAIN: begin
          if (!not_empty_s) begin
            cur_domain_r <= pending_domain_r;
            state_r      <= ST_ISSUE;
          end
        end
        default: state_r <= ST_ISSUE;
      endcase
    end
  end
`else
  // Without domain isolation the scheduler never leaves the issue state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_ISSUE;
    end else begin
      state_r <= ST_ISSUE;
    end
  end
`endif

endmodule

// File: tb/tb_plab5_mcore_mem_req_sched.sv
// Self-checking bench for plab5_mcore_mem_req_sched: directed steps plus a
// randomized phase, compared against a queue-based reference model.
module tb_plab5_mcore_mem_req_sched;

  localparam int O = 8;
  localparam int A = 32;
  localparam int D = 32;
  localparam int DEPTH = 4;
  localparam int REQW  = 3 + O + A + 2 + D;
  localparam int RESPW = 3 + O + 2 + D;

  logic clk = 1'b0;
  logic reset;
  logic req0_val, req0_rdy, req0_domain;
  logic req1_val, req1_rdy, req1_domain;
  logic [REQW-1:0] req0_msg, req1_msg, memreq_msg;
  logic memreq_val, memreq_rdy, memreq_domain;
  logic memresp_val, memresp_rdy;
  logic [RESPW-1:0] memresp_msg, resp0_msg, resp1_msg;
  logic resp0_val, resp0_rdy, resp1_val, resp1_rdy;

  plab5_mcore_mem_req_sched #(
    .p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(D),
    .p_max_outstanding(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg), .req0_domain(req0_domain),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg), .req1_domain(req1_domain),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memreq_domain(memreq_domain),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passes = 0;
  int fails = 0;

  // Reference model: queue of owners of outstanding requests (oldest first)
  // and the requester preferred on the next tie.
  int q[$];
  int pref = 0;
  bit fired0, fired1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REQW-1:0] rreq();
    return REQW'({$urandom, $urandom, $urandom});
  endfunction

  function automatic logic [RESPW-1:0] rresp();
    return RESPW'({$urandom, $urandom});
  endfunction

  // One cycle: called just after a falling edge with inputs already driven
  task automatic step(input string tag);
    int  win;
    bit  issue;
    bit  exp_mrdy;
    bit  own0, own1;
    #1;
    win = -1;
    if (req0_val && req1_val) win = pref;
    else if (req0_val)        win = 0;
    else if (req1_val)        win = 1;
    issue = (win >= 0) && (q.size() < DEPTH);
    chk($sformatf("%s.memreq_val", tag), memreq_val, issue);
    if (issue) begin
      chk($sformatf("%s.memreq_msg", tag), memreq_msg, (win == 1) ? req1_msg : req0_msg);
      chk($sformatf("%s.memreq_domain", tag), memreq_domain,
          (win == 1) ? req1_domain : req0_domain);
    end
    chk($sformatf("%s.req0_rdy", tag), req0_rdy, issue && win == 0 && memreq_rdy);
    chk($sformatf("%s.req1_rdy", tag), req1_rdy, issue && win == 1 && memreq_rdy);
    own0 = (q.size() > 0) && (q[0] == 0);
    own1 = (q.size() > 0) && (q[0] == 1);
    exp_mrdy = (own0 && resp0_rdy) || (own1 && resp1_rdy);
    chk($sformatf("%s.memresp_rdy", tag), memresp_rdy, exp_mrdy);
    chk($sformatf("%s.resp0_val", tag), resp0_val, memresp_val && own0);
    chk($sformatf("%s.resp1_val", tag), resp1_val, memresp_val && own1);
    if (memresp_val && own0) chk($sformatf("%s.resp0_msg", tag), resp0_msg, memresp_msg);
    if (memresp_val && own1) chk($sformatf("%s.resp1_msg", tag), resp1_msg, memresp_msg);
    @(posedge clk);
    fired0 = issue && memreq_rdy && win == 0;
    fired1 = issue && memreq_rdy && win == 1;
    if (memresp_val && exp_mrdy) void'(q.pop_front());
    if (issue && memreq_rdy) begin
      q.push_back(win);
      pref = 1 - win;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_val = 1'b0; req1_val = 1'b0;
    req0_domain = 1'b0; req1_domain = 1'b0;
    memreq_rdy = 1'b0; memresp_val = 1'b0;
    resp0_rdy = 1'b0; resp1_rdy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    pref = 0;
  endtask

  task automatic drain(input int n);
    req0_val = 1'b0; req1_val = 1'b0;
    memresp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      memresp_msg = rresp();
      step("drain");
    end
    memresp_val = 1'b0;
  endtask

  logic [REQW-1:0] m;

  initial begin
    reset = 1'b1;
    idle_inputs();
    req0_msg = '0; req1_msg = '0; memresp_msg = '0;
    @(negedge clk);

    // Outputs stay low during reset even with every input active
    req0_val = 1'b1; req1_val = 1'b1; memreq_rdy = 1'b1;
    memresp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    #1;
    chk("rst.memreq_val", memreq_val, 1'b0);
    chk("rst.req0_rdy", req0_rdy, 1'b0);
    chk("rst.req1_rdy", req1_rdy, 1'b0);
    chk("rst.memresp_rdy", memresp_rdy, 1'b0);
    chk("rst.resp0_val", resp0_val, 1'b0);
    chk("rst.resp1_val", resp1_val, 1'b0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    q.delete();
    pref = 0;

    // Single request to address 0x100 from requester 0, then its response
    m = '0;
    m[65:34] = 32'h100;
    req0_msg = m;
    req0_val = 1'b1; memreq_rdy = 1'b1;
    step("single");
    drain(1);

    // Both requesters continuously valid: alternating grants, responses follow
    req0_val = 1'b1; req1_val = 1'b1; memreq_rdy = 1'b1;
    memresp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_msg = rreq(); req1_msg = rreq(); memresp_msg = rresp();
      step("rr");
    end
    drain(1);

    // Fill the tracker, then a pop in the same cycle must not enable an issue
    req0_val = 1'b1; req1_val = 1'b1; memreq_rdy = 1'b1;
    memresp_val = 1'b0;
    for (int i = 0; i < DEPTH; i++) step("fill");
    step("full");
    chk("full.blocked", memreq_val, 1'b0);
    memresp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    step("full_pop");
    memresp_val = 1'b0;
    step("after_pop");
    drain(DEPTH + 1);

    // Stray response with nothing outstanding, then a stalled response
    memresp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    step("stray");
    memresp_val = 1'b0;
    req0_val = 1'b1; memreq_rdy = 1'b1;
    step("one");
    req0_val = 1'b0;
    memresp_val = 1'b1; resp0_rdy = 1'b0;
    step("stall");
    resp0_rdy = 1'b1;
    step("unstall");
    memresp_val = 1'b0;

    // Randomized traffic with val/msg held until accepted
    fired0 = 1'b0; fired1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!req0_val || fired0) begin
        req0_val = 1'($urandom_range(0, 1)); req0_msg = rreq();
`ifdef PLAB5_MCORE_MEMREQ_SCHED_DOMAIN_ISO_EN
        req0_domain = 1'b0;
`else
        req0_domain = 1'($urandom_range(0, 1));
`endif
      end
      if (!req1_val || fired1) begin
        req1_val = 1'($urandom_range(0, 1)); req1_msg = rreq();
`ifdef PLAB5_MCORE_MEMREQ_SCHED_DOMAIN_ISO_EN
        req1_domain = 1'b0;
`else
        req1_domain = 1'($urandom_range(0, 1));
`endif
      end
      memreq_rdy  = 1'($urandom_range(0, 1));
      memresp_val = 1'($urandom_range(0, 1));
      memresp_msg = rresp();
      resp0_rdy   = 1'($urandom_range(0, 1));
      resp1_rdy   = 1'($urandom_range(0, 1));
      step("rand");
    end
    req0_domain = 1'b0; req1_domain = 1'b0;
    drain(DEPTH + 1);

    // Asynchronous reset in the middle of a cycle with three outstanding
    req0_val = 1'b1; req1_val = 1'b1; memreq_rdy = 1'b1;
    for (int i = 0; i < 3; i++) step("pre_rst");
    memresp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk("midrst.memreq_val", memreq_val, 1'b0);
    chk("midrst.req0_rdy", req0_rdy, 1'b0);
    chk("midrst.req1_rdy", req1_rdy, 1'b0);
    chk("midrst.memresp_rdy", memresp_rdy, 1'b0);
    chk("midrst.resp0_val", resp0_val, 1'b0);
    chk("midrst.resp1_val", resp1_val, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    pref = 0;
    step("post_rst");
    memresp_val = 1'b0;
    drain(2);

    // Domain switch: req0 (domain 0) issues twice, then req1 (domain 1)
    do_reset();
    req0_val = 1'b1; req0_domain = 1'b0; memreq_rdy = 1'b1;
    step("dom_a");
    step("dom_b");
    req0_val = 1'b0; req1_val = 1'b1; req1_domain = 1'b1;
`ifdef PLAB5_MCORE_MEMREQ_SCHED_DOMAIN_ISO_EN
    #1;
    chk("iso.wait0", memreq_val, 1'b0);
    @(negedge clk);
    memresp_val = 1'b1; resp0_rdy = 1'b1;
    #1;
    chk("iso.wait1", memreq_val, 1'b0);
    chk("iso.pop1", memresp_rdy, 1'b1);
    @(negedge clk);
    #1;
    chk("iso.wait2", memreq_val, 1'b0);
    chk("iso.pop2", memresp_rdy, 1'b1);
    @(negedge clk);
    memresp_val = 1'b0;
    #1;
    chk("iso.drain_exit", memreq_val, 1'b0);
    @(negedge clk);
    #1;
    chk("iso.issue", memreq_val, 1'b1);
    chk("iso.req1_rdy", req1_rdy, 1'b1);
    chk("iso.domain", memreq_domain, 1'b1);
    @(negedge clk);
`else
    step("dom_c");
    chk("noiso.immediate", fired1, 1'b1);
    drain(3);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
